// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_START,
    ARB_WAIT_BUSY,
    ARB_WAIT_DONE,
    ARB_HOLD
  } uart_arb_state_e;

  function automatic int unsigned uart_rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Rotating-priority picker: the search starts one past the last grant and
// wraps, so the most recent winner has the lowest priority.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       any
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    any    = 1'b0;
    idx    = ID_W'(uart_rr_next(32'(last_grant), NUM_REQ));
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
      idx = ID_W'(uart_rr_next(32'(idx), NUM_REQ));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers, round-robin,
// with optional packet lock so a multi-byte packet goes out uninterrupted.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_last,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [UART_BYTE_W-1:0]         tx_data,
  input  logic                           tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           grant_active,
  output logic                           timeout_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BUSY_TIMEOUT);

  uart_arb_state_e        state_q, state_d;
  logic                   lock_q, lock_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [ID_W-1:0]        gid_q, gid_d;
  logic [UART_BYTE_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [UART_BYTE_W-1:0] reqByte [NUM_REQ];
  logic [NUM_REQ-1:0]     pickGnt;
  logic [ID_W-1:0]        pickId;
  logic                   pickAny;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign reqByte[g] = req_data[g*UART_BYTE_W +: UART_BYTE_W];
  end

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .gnt        (pickGnt),
    .gnt_id     (pickId),
    .any        (pickAny)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      lock_q  <= 1'b0;
      last_q  <= ID_W'(NUM_REQ - 1);
      gid_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ready never looks at tx_busy; the pointer moves only on IDLE accepts.
  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    last_d      = last_q;
    gid_d       = gid_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    req_ready   = '0;
    timeout_err = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pickAny) begin
          req_ready = pickGnt;
          data_d    = reqByte[pickId];
          gid_d     = pickId;
          last_d    = pickId;
          lock_d    = !req_last[pickId];
          state_d   = ARB_START;
        end
      end
      ARB_START: begin
        cnt_d   = '0;
        state_d = ARB_WAIT_BUSY;
      end
      ARB_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ARB_WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          timeout_err = 1'b1;
          lock_d      = 1'b0;
          state_d     = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ARB_WAIT_DONE: begin
        if (!tx_busy) state_d = lock_q ? ARB_HOLD : ARB_IDLE;
      end
      ARB_HOLD: begin
        req_ready[gid_q] = req_valid[gid_q];
        if (req_valid[gid_q]) begin
          data_d  = reqByte[gid_q];
          lock_d  = !req_last[gid_q];
          state_d = ARB_START;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign tx_start     = (state_q == ARB_START);
  assign tx_data      = data_q;
  assign grant_id     = gid_q;
  assign grant_active = (state_q != ARB_IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_top` transmitter among `NUM_REQ` byte producers. It accepts bytes over a per-requester valid/ready handshake and selects between requesters round-robin. It sequences `tx_start`/`tx_data` against `uart_top`'s `tx_busy`, and it can lock the channel to one requester for a multi-byte packet. It sits between the system's byte sources and the `tx_start`/`tx_data`/`tx_busy` ports of `uart_top`. Baud, parity and stop-bit configuration are not touched by this block.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 16: cycles allowed between `tx_start` and `tx_busy` rising before the byte is abandoned; must be ≥ 2.
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-low. All state updates on the `clk` rising edge while `rst`=0.
- `req_valid` in `NUM_REQ`: requester i has a byte.
- `req_data` in `NUM_REQ*8`: byte of requester i is `req_data[8*i +: 8]`.
- `req_last` in `NUM_REQ`: the offered byte ends requester i's packet; 1 for single bytes.
- `req_ready` out `NUM_REQ`: one-hot or zero. A byte transfers in a cycle where `req_valid[i]` and `req_ready[i]` are both 1.
- `tx_start` out 1: one-cycle start pulse to `uart_top`.
- `tx_data` out 8: byte to `uart_top`, stable from `tx_start` until the byte completes.
- `tx_busy` in 1: from `uart_top`.
- `grant_id` out `$clog2(NUM_REQ)`: current or last owner.
- `grant_active` out 1: a byte is in flight or the channel is locked.
- `timeout_err` out 1: one-cycle pulse when the busy timeout fires.

## Operation
- The state machine has five states: IDLE, START, WAIT_BUSY, WAIT_DONE, HOLD.
- **IDLE**
  - If any `req_valid` is set, pick the winner round-robin: the search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
  - `req_ready[winner]` is 1 combinationally in that cycle.
  - On the transfer: latch the byte into `tx_data`, set `grant_id`=winner and `last_grant`=winner, set `lock` = !`req_last`, then go to START.
- **START**
  - `tx_start`=1 for exactly one cycle, then go to WAIT_BUSY.
  - The busy counter is cleared here.
- **WAIT_BUSY**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When it reaches `BUSY_TIMEOUT`-1 without busy: pulse `timeout_err`, clear `lock`, go to IDLE.
- **WAIT_DONE**
  - When `tx_busy`=0, go to HOLD if `lock`=1, else go to IDLE.
- **HOLD**
  - Only `req_ready[grant_id]` may be 1, and it equals `req_valid[grant_id]`. Other requesters are ignored.
  - On the transfer: latch the byte, set `lock` = !`req_last`, go to START.
  - The lock has no time limit. A locked owner that stops offering bytes stalls the channel by design.
- `grant_active` = (state ≠ IDLE).
- The round-robin pointer advances only on accepts made from IDLE. Bytes accepted in HOLD do not change fairness.

## Timing
- Reset values:
  - state IDLE, `lock`=0, `last_grant`=`NUM_REQ`-1 (requester 0 wins first).
  - `req_ready`=0, `tx_start`=0, `tx_data`=8'h00, `grant_id`=0, `grant_active`=0, `timeout_err`=0.
- Accept at cycle T → `tx_start` at T+1 → `tx_busy` is expected by T+1+`BUSY_TIMEOUT`.
- Gap between bytes: `tx_busy` sampled 0 in WAIT_DONE at cycle D → accept earliest at D+1 → next `tx_start` at D+2.
- `req_ready` is a combinational function of state, `lock`, `last_grant` and `req_valid`. It never depends on `tx_busy` in the same cycle.
- If all requesters are valid simultaneously, exactly one is granted. Grants rotate 0,1,2,3,0…
- If `req_valid` drops before the transfer, no transfer occurs and no state changes.
- Reset asserted mid-byte: the arbiter returns to IDLE on the next edge. `uart_top` shares `rst`, so the line is also reset and no byte is resumed.
- `tx_busy` already 1 at START (a stale frame) counts as busy. The arbiter does not check for this.

## Structure
- `uart_pkg` holds:
  - `uart_arb_state_e` (the five states);
  - `UART_BYTE_W`=8;
  - `uart_rr_next()`, a function returning the next index modulo N.
- One sub-module, `uart_rr_pick`: combinational rotating-priority picker.
  - Inputs: `req` vector, `last_grant`.
  - Outputs: one-hot `gnt`, encoded `gnt_id`, `any`.
- The top holds the state machine, the data latch and the timeout counter.

## Test plan
- **Single byte:** requester 2 offers 8'hA5 with `req_last`=1, looped back to a real `uart_top` (divisor 434, parity even) → one `tx_start`, `rx_data`=8'hA5, `grant_id`=2, `grant_active` returns to 0.
- **Fairness:** all four requesters continuously valid with `req_last`=1 and data 8'h10+i → transmit order 0,1,2,3,0,1, with no requester starved.
- **Packet lock:** requester 1 sends 8'h11, 8'h22, 8'h33 (last on 8'h33) while requester 3 is valid throughout → the three bytes go out back to back before any byte from requester 3. During HOLD, `req_ready[3]` stays 0.
- **Lock stall:** requester 1 sends 8'h11 without last, then drops valid for 50 cycles → the arbiter stays in HOLD with no `tx_start`. When requester 1 sends 8'h22 with last, it is transmitted.
- **Timeout:** `tx_busy` stubbed to 0 → `timeout_err` pulses exactly `BUSY_TIMEOUT` cycles after the accept cycle T+1 (`tx_start`), `lock` clears, and the next requester is granted.
- **Reset mid-frame:** `rst`=0 for one cycle during WAIT_DONE → all outputs at their reset values on the next cycle, and the next grant goes to requester 0.
